// File: rtl/cpu_mc_pkg.sv
// rtl/cpu_mc_pkg.sv - encodings, states and field positions for the multi-cycle load/store core
package cpu_mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [3:0] OP_HALT = 4'd0;
   localparam logic [3:0] OP_LOAD = 4'd1;
   localparam logic [3:0] OP_JUMP = 4'd3;
   localparam logic [3:0] OP_ADD  = 4'd4;
   localparam logic [3:0] OP_SUB  = 4'd5;
   localparam logic [3:0] OP_STR  = 4'd7;

   localparam logic [3:0] CC_AL = 4'd0;
   localparam logic [3:0] CC_Z  = 4'd1;
   localparam logic [3:0] CC_NZ = 4'd2;
   localparam logic [3:0] CC_C  = 4'd3;
   localparam logic [3:0] CC_N  = 4'd4;

   localparam int OP_HI   = 31;
   localparam int OP_LO   = 28;
   localparam int MODE_HI = 27;
   localparam int MODE_LO = 24;
   localparam int RD_HI   = 23;
   localparam int RD_LO   = 20;
   localparam int RS_HI   = 19;
   localparam int RS_LO   = 16;
   localparam int IMM_HI  = 15;

   localparam int MODE_MEM   = 27;
   localparam int MODE_REG   = 26;
   localparam int MODE_UPPER = 25;
   localparam int LINK_BIT   = 19;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

endpackage

// File: rtl/cpu_mc_alu.sv
// rtl/cpu_mc_alu.sv - add/subtract with {V,C,N,Z}; C is not-borrow on subtract
module cpu_mc_alu
   import cpu_mc_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              sub_i,
   output logic [DATA_W-1:0] y_o,
   output logic [3:0]        flags_o
);

   logic [DATA_W-1:0] b_eff;
   logic              carry;

   always_comb begin
      b_eff = sub_i ? ~b_i : b_i;
      {carry, y_o} = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};
      flags_o         = '0;
      flags_o[FLAG_Z] = (y_o == '0);
      flags_o[FLAG_N] = y_o[DATA_W-1];
      flags_o[FLAG_C] = carry;
      flags_o[FLAG_V] = (a_i[DATA_W-1] == b_eff[DATA_W-1]) && (y_o[DATA_W-1] != a_i[DATA_W-1]);
   end

endmodule

// File: rtl/cpu_mc_core.sv
// rtl/cpu_mc_core.sv - multi-cycle load/store CPU with valid/ready memory port
// Undefined opcodes trap when CPU_MC_TRAP_EN is defined, otherwise they are NOPs.
module cpu_mc_core
   import cpu_mc_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter logic [DATA_W-1:0] RESET_PC = 32'hB000_0000
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic [3:0]        flags
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   state_t            state_q, state_d;
   logic [31:0]       ir_q, ir_d;
   logic [DATA_W-1:0] rdv_q, rdv_d, rsv_q, rsv_d, res_q, res_d;
   logic [3:0]        fpend_q, fpend_d, flags_q, flags_d;
   logic              take_q, take_d, trap_q, trap_d;
   logic              req_q, req_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] regs_q [16];

   logic              pc_inc, wr_en, lnk_en;
   logic [3:0]        wr_idx, lnk_idx;
   logic [DATA_W-1:0] wr_data, lnk_data, pc_next;

   logic [3:0]        op;
   logic [DATA_W-1:0] imm_z, imm_s, ea, alu_b, alu_y;
   logic [3:0]        alu_flags;

   assign op    = ir_q[OP_HI:OP_LO];
   assign imm_z = {{(DATA_W-16){1'b0}}, ir_q[IMM_HI:0]};
   assign imm_s = {{(DATA_W-16){ir_q[IMM_HI]}}, ir_q[IMM_HI:0]};
   assign ea    = rsv_q + imm_s;
   assign alu_b = ir_q[MODE_REG] ? rsv_q : imm_s;

   cpu_mc_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i     (rdv_q),
      .b_i     (alu_b),
      .sub_i   (op == OP_SUB),
      .y_o     (alu_y),
      .flags_o (alu_flags)
   );

   always_comb begin
      state_d  = state_q;  ir_d    = ir_q;    rdv_d   = rdv_q;  rsv_d  = rsv_q;
      res_d    = res_q;    fpend_d = fpend_q; take_d  = take_q; flags_d = flags_q;
      trap_d   = trap_q;   req_d   = req_q;   we_d    = we_q;   addr_d = addr_q;
      wdata_d  = wdata_q;
      pc_inc   = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = ir_q[RD_HI:RD_LO];
      wr_data  = res_q;
      lnk_en   = 1'b0;
      lnk_idx  = {1'b1, ir_q[RS_HI-1:RS_LO]};
      lnk_data = regs_q[0];
      pc_next  = regs_q[0];
      case (state_q)
         S_FETCH: begin
            // First cycle after reset has no request yet; WB normally issues it.
            if (!req_q) begin
               req_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = regs_q[0][ADDR_W-1:0] & ALIGN_MASK;
            end else if (mem_ready) begin
               ir_d    = mem_rdata[31:0];
               pc_inc  = 1'b1;
               req_d   = 1'b0;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            rdv_d   = regs_q[ir_q[RD_HI:RD_LO]];
            rsv_d   = regs_q[ir_q[RS_HI:RS_LO]];
            state_d = (op == OP_HALT) ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            state_d = S_WB;
            case (op)
               OP_LOAD: begin
                  if (ir_q[MODE_MEM]) begin
                     req_d   = 1'b1;
                     we_d    = 1'b0;
                     addr_d  = ea[ADDR_W-1:0] & ALIGN_MASK;
                     state_d = S_MEM;
                  end else if (ir_q[MODE_REG]) begin
                     res_d = rsv_q;
                  end else if (ir_q[MODE_UPPER]) begin
                     res_d        = rdv_q;
                     res_d[31:16] = ir_q[IMM_HI:0];
                  end else begin
                     res_d = imm_z;
                  end
               end
               OP_STR: begin
                  req_d   = 1'b1;
                  we_d    = 1'b1;
                  addr_d  = ea[ADDR_W-1:0] & ALIGN_MASK;
                  wdata_d = rdv_q;
                  state_d = S_MEM;
               end
               OP_ADD, OP_SUB: begin
                  res_d   = alu_y;
                  fpend_d = alu_flags;
               end
               OP_JUMP: begin
                  res_d = rdv_q + imm_s;
                  case (ir_q[MODE_HI:MODE_LO])
                     CC_AL:   take_d = 1'b1;
                     CC_Z:    take_d = flags_q[FLAG_Z];
                     CC_NZ:   take_d = !flags_q[FLAG_Z];
                     CC_C:    take_d = flags_q[FLAG_C];
                     CC_N:    take_d = flags_q[FLAG_N];
                     default: take_d = 1'b0;
                  endcase
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (!we_q) res_d = mem_rdata;
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = S_WB;
            end
         end
         S_WB: begin
            case (op)
               OP_LOAD: wr_en = 1'b1;
               OP_ADD, OP_SUB: begin
                  wr_en   = 1'b1;
                  flags_d = fpend_q;
                  trap_d  = 1'b0;
               end
               OP_JUMP: begin
                  // Link lands in r8..r15, so it never collides with the r0 write.
                  wr_en  = take_q;
                  wr_idx = 4'd0;
                  lnk_en = take_q && ir_q[LINK_BIT];
               end
               OP_STR: ;
               default: begin
`ifdef CPU_MC_TRAP_EN
                  wr_en   = 1'b1;
                  wr_idx  = 4'd0;
                  wr_data = RESET_PC + DATA_W'(8);
                  lnk_en  = 1'b1;
                  lnk_idx = 4'd15;
                  trap_d  = 1'b1;
`else
                  wr_en   = 1'b0;
`endif
               end
            endcase
            if (wr_en && wr_idx == 4'd0) pc_next = wr_data;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = pc_next[ADDR_W-1:0] & ALIGN_MASK;
            state_d = S_FETCH;
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_FETCH;  ir_q    <= '0;  rdv_q   <= '0;  rsv_q  <= '0;
         res_q   <= '0;       fpend_q <= '0;  take_q  <= 1'b0; flags_q <= '0;
         trap_q  <= 1'b0;     req_q   <= 1'b0; we_q   <= 1'b0; addr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;  ir_q    <= ir_d;    rdv_q  <= rdv_d;  rsv_q   <= rsv_d;
         res_q   <= res_d;    fpend_q <= fpend_d; take_q <= take_d; flags_q <= flags_d;
         trap_q  <= trap_d;   req_q   <= req_d;   we_q   <= we_d;   addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) regs_q[i] <= (i == 0) ? RESET_PC : '0;
      end else begin
         if (pc_inc) regs_q[0] <= regs_q[0] + DATA_W'(4);
         if (wr_en)  regs_q[wr_idx] <= wr_data;
         if (lnk_en) regs_q[lnk_idx] <= lnk_data;
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign halted    = (state_q == S_HALT);
   assign flags     = {flags_q[FLAG_V] | trap_q, flags_q[FLAG_C:FLAG_Z]};

endmodule

// File: tb/tb_cpu_mc_core.sv
// tb/tb_cpu_mc_core.sv - directed program run against cpu_mc_core with a wait-state memory model
module tb_cpu_mc_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req, mem_we, mem_ready, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] prog [256];
   logic [31:0] dmem [256];
   int          fetch_wait = 0;
   int          data_wait = 3;
   logic        idle_ready = 1'b1;
   int          n_writes = 0;
   logic [31:0] wr_addr = '0, wr_data = '0;
   int          we_cycles = 0;
   int          unstable = 0;
   logic [31:0] fa_q[$];
   int          fc_q[$];
   logic [3:0]  ff_q[$];

   cpu_mc_core dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .halted    (halted),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] md,
                                       input logic [3:0] rd, input logic [3:0] rs,
                                       input logic [15:0] imm);
      return {op, md, rd, rs, imm};
   endfunction

   // Memory model: decides mem_ready for the next rising edge on each falling edge.
   initial begin
      int          cnt;
      int          w;
      logic        is_prog;
      logic [31:0] first_a, first_d;
      cnt = 0;
      mem_ready = 1'b1;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            is_prog = (mem_addr[31:28] == 4'hB);
            w = is_prog ? fetch_wait : data_wait;
            if (mem_we) begin
               we_cycles++;
               if (we_cycles == 1) begin
                  first_a = mem_addr;
                  first_d = mem_wdata;
               end else if (mem_addr !== first_a || mem_wdata !== first_d) begin
                  unstable++;
               end
            end
            if (cnt >= w) begin
               mem_ready = 1'b1;
               mem_rdata = is_prog ? prog[mem_addr[9:2]] : dmem[mem_addr[9:2]];
               if (mem_we) begin
                  dmem[mem_addr[9:2]] = mem_wdata;
                  n_writes++;
                  wr_addr = mem_addr;
                  wr_data = mem_wdata;
               end else if (is_prog) begin
                  fa_q.push_back(mem_addr);
                  fc_q.push_back(cyc);
                  ff_q.push_back(flags);
               end
            end else begin
               mem_ready = 1'b0;
            end
            cnt++;
         end else begin
            cnt = 0;
            mem_ready = idle_ready;
         end
      end
   end

   logic [31:0] exp_fa [19];
   int          exp_dt [18];
   logic [31:0] exp_reg [16];
   int          req_seen;

   initial begin
      for (int i = 0; i < 256; i++) prog[i] = 32'h0;
      prog[0]  = enc(4'h1, 4'h0, 4'd1, 4'd0, 16'h1234);
      prog[1]  = enc(4'h1, 4'h2, 4'd1, 4'd0, 16'hCAFE);
      prog[2]  = enc(4'h1, 4'h0, 4'd2, 4'd0, 16'hFFFF);
      prog[3]  = enc(4'h1, 4'h2, 4'd2, 4'd0, 16'h7FFF);
      prog[4]  = enc(4'h4, 4'h0, 4'd2, 4'd0, 16'h0001);
      prog[5]  = enc(4'h1, 4'h0, 4'd3, 4'd0, 16'h0005);
      prog[6]  = enc(4'h5, 4'h4, 4'd3, 4'd3, 16'h0000);
      prog[7]  = enc(4'h1, 4'h0, 4'd4, 4'd0, 16'h0100);
      prog[8]  = enc(4'h7, 4'h0, 4'd1, 4'd4, 16'h0010);
      prog[9]  = enc(4'h1, 4'h8, 4'd6, 4'd4, 16'h0010);
      prog[10] = enc(4'h1, 4'h0, 4'd5, 4'd0, 16'h0100);
      prog[11] = enc(4'h1, 4'h2, 4'd5, 4'd0, 16'hB000);
      prog[12] = enc(4'h3, 4'h1, 4'd5, 4'hF, 16'h0000);
      prog[64] = enc(4'h4, 4'h0, 4'd7, 4'd0, 16'h0001);
      prog[65] = enc(4'h3, 4'h1, 4'd5, 4'h9, 16'h0000);
      prog[66] = enc(4'h3, 4'h0, 4'd5, 4'd0, 16'h0020);
      prog[72] = enc(4'h2, 4'h1, 4'd1, 4'd0, 16'h1111);
      prog[73] = enc(4'h1, 4'h4, 4'd8, 4'd1, 16'h0000);
      prog[74] = enc(4'h0, 4'h0, 4'd0, 4'd0, 16'h0000);

      for (int i = 0; i < 13; i++) exp_fa[i] = 32'hB000_0000 + 32'(4 * i);
      exp_fa[13] = 32'hB000_0100; exp_fa[14] = 32'hB000_0104; exp_fa[15] = 32'hB000_0108;
      exp_fa[16] = 32'hB000_0120; exp_fa[17] = 32'hB000_0124; exp_fa[18] = 32'hB000_0128;
      for (int i = 0; i < 18; i++) exp_dt[i] = (i == 8 || i == 9) ? 8 : 4;

      exp_reg = '{32'hB000_012C, 32'hCAFE_1234, 32'h8000_0000, 32'h0, 32'h100, 32'hB000_0100,
                  32'hCAFE_1234, 32'h1, 32'hCAFE_1234, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'hB000_0034};

      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req", {31'b0, mem_req}, 32'h0);
      check("rst_we", {31'b0, mem_we}, 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      check("rst_flags", {28'b0, flags}, 32'h0);

      reset = 1'b1;
      @(negedge clk);
      check("first_req", {31'b0, mem_req}, 32'h1);
      check("first_addr", mem_addr, 32'hB000_0000);
      check("first_we", {31'b0, mem_we}, 32'h0);

      for (int i = 0; i < 600; i++) begin
         if (halted) break;
         @(negedge clk);
      end
      check("halted", {31'b0, halted}, 32'h1);
      req_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_req) req_seen++;
      end
      check("halt_no_req", 32'(req_seen), 32'h0);

      check("n_fetch", 32'(fa_q.size()), 32'd19);
      for (int i = 0; i < 19 && i < fa_q.size(); i++)
         check($sformatf("fetch_addr[%0d]", i), fa_q[i], exp_fa[i]);
      for (int i = 0; i < 18 && i + 1 < fc_q.size(); i++)
         check($sformatf("fetch_gap[%0d]", i), 32'(fc_q[i+1] - fc_q[i]), 32'(exp_dt[i]));
      if (ff_q.size() > 14) begin
         check("flags_add_ovf", {28'b0, ff_q[5]}, 32'hA);
         check("flags_sub_zero", {28'b0, ff_q[7]}, 32'h5);
         check("flags_after_jump", {28'b0, ff_q[13]}, 32'h5);
         check("flags_add_small", {28'b0, ff_q[14]}, 32'h0);
      end else begin
         check("flags_log_len", 32'(ff_q.size()), 32'd19);
      end

      check("str_count", 32'(n_writes), 32'd1);
      check("str_addr", wr_addr, 32'h110);
      check("str_data", wr_data, 32'hCAFE_1234);
      check("str_req_cycles", 32'(we_cycles), 32'd4);
      check("str_stable", 32'(unstable), 32'd0);
      for (int i = 0; i < 16; i++)
         check($sformatf("r%0d", i), dut.regs_q[i], exp_reg[i]);
      check("final_flags", {28'b0, flags}, 32'h0);

      reset = 1'b0;
      repeat (2) @(negedge clk);
      fetch_wait = 10000;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("stall_req", {31'b0, mem_req}, 32'h1);
      check("stall_addr", mem_addr, 32'hB000_0000);
      reset = 1'b0;
      @(negedge clk);
      check("abort_req", {31'b0, mem_req}, 32'h0);
      check("abort_r0", dut.regs_q[0], 32'hB000_0000);
      check("abort_r1", dut.regs_q[1], 32'h0);
      check("abort_halted", {31'b0, halted}, 32'h0);
      fetch_wait = 0;
      reset = 1'b1;
      @(negedge clk);
      check("refetch_req", {31'b0, mem_req}, 32'h1);
      check("refetch_addr", mem_addr, 32'hB000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
